// File: rtl/mem_fifo_param.sv
// ============================================================================
// Module   : mem_fifo_param
// Purpose  : Parametrised synchronous FIFO with occupancy, full/empty/almost-full
//            and sticky overflow/underflow status. Define MEM_FIFO_FWFT_EN for
//            first-word-fall-through reads; otherwise reads are registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [AW:0]       count,
    output logic              ovf,
    output logic              udf
);

    localparam int            CW          = AW + 1;
    localparam logic [AW:0]   C_DEPTH     = CW'(DEPTH);
    localparam logic [AW:0]   C_AFULL     = CW'(AFULL_TH);
    localparam logic [AW:0]   C_CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              w_push;
    logic              w_pop;

    // Flags decode the registered count, so push/pop see start-of-cycle state.
    assign full        = (count_q == C_DEPTH);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= C_AFULL);
    assign count       = count_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;

    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        // A new error event in the same cycle as clr_err keeps the flag set.
        ovf_d = (ovf_q & ~clr_err) | (wr_en & full);
        udf_d = (udf_q & ~clr_err) | (rd_en & empty);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef MEM_FIFO_FWFT_EN
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = ~empty;
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_pop;
            if (w_pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

`default_nettype wire
